// File: rtl/uart_rx.sv
// uart_rx: 8-bit UART receiver, selectable even/odd parity, one stop bit.
// The bit clock is a 16x oversampling tick derived from the system clock.
// Define UART_RX_FIFO_EN to replace the single holding register with a 4-entry FIFO.
module uart_rx #(
  parameter int unsigned CLK_FREQ   = 24000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       Parity_sel,
  input  logic       rd_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       data_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned DIV          = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned TW           = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SW           = $clog2(OVERSAMPLE);
  localparam int unsigned START_SAMPLE = OVERSAMPLE / 2 - 1;
  localparam int unsigned LAST_SAMPLE  = OVERSAMPLE - 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } state_e;

  state_e          state_q, state_d;
  logic            rx_meta_q, rxs_q;
  logic [TW-1:0]   tick_cnt_q;
  logic            tick, tick_clr;
  logic [SW-1:0]   samp_cnt_q, samp_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            psel_q, psel_d;
  logic            perr_q, perr_d;
  logic            complete;
  logic            sample;

  // Two-flop synchronizer for the asynchronous serial line; idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
    end
  end

  // Oversampling tick divider; restarted on a start edge so sampling phase is fixed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
    end else if (tick_clr || tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + 1'b1;
    end
  end

  assign tick   = (tick_cnt_q == TW'(DIV - 1));
  assign sample = tick && (samp_cnt_q == SW'(LAST_SAMPLE));

  // FSM and datapath state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      samp_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      psel_q     <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      samp_cnt_q <= samp_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      psel_q     <= psel_d;
      perr_q     <= perr_d;
    end
  end

  // Next-state logic: frame sequencing and bit sampling.
  always_comb begin
    state_d    = state_q;
    samp_cnt_d = samp_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    psel_d     = psel_q;
    perr_d     = perr_q;
    tick_clr   = 1'b0;
    complete   = 1'b0;
    if (tick && (state_q inside {StStart, StData, StParity, StStop})) begin
      samp_cnt_d = samp_cnt_q + 1'b1;
    end
    case (state_q)
      StIdle: begin
        if (!rxs_q) begin
          state_d    = StStart;
          tick_clr   = 1'b1;
          samp_cnt_d = '0;
        end
      end
      StStart: begin
        // Decide on the tick that brings the sample count to mid-bit.
        if (tick && (samp_cnt_q == SW'(START_SAMPLE - 1))) begin
          if (rxs_q) begin
            state_d = StIdle;
          end else begin
            psel_d     = Parity_sel;
            samp_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = StData;
          end
        end
      end
      StData: begin
        if (sample) begin
          shift_d   = {rxs_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) begin
            state_d = StParity;
          end
        end
      end
      StParity: begin
        if (sample) begin
          perr_d  = (^shift_q) ^ rxs_q ^ psel_q;
          state_d = StStop;
        end
      end
      StStop: begin
        if (sample) begin
          complete = 1'b1;
          state_d  = rxs_q ? StIdle : StBreak;
        end
      end
      StBreak: begin
        // Line must return high before another start edge is accepted.
        if (rxs_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Per-frame status: one-cycle valid pulse and flags held until the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_valid <= complete;
      if (complete) begin
        parity_err <= perr_q;
        frame_err  <= ~rxs_q;
      end
    end
  end

  assign busy = (state_q != StIdle);

`ifdef UART_RX_FIFO_EN
  logic [7:0] mem_q [4];
  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0] count_q;
  logic       push, pop, full;

  assign full = (count_q == 3'd4);
  assign pop  = rd_ack && (count_q != 3'd0);
  // A same-cycle pop frees the slot for the incoming byte.
  assign push = complete && (!full || pop);

  // Receive FIFO storage, pointers, occupancy and sticky overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      overrun  <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + {2'b00, push} - {2'b00, pop};
      if (complete && !push) begin
        overrun <= 1'b1;
      end else if (rd_ack && !complete) begin
        overrun <= 1'b0;
      end
    end
  end

  assign rx_data    = mem_q[rd_ptr_q];
  assign data_ready = (count_q != 3'd0);
`else
  // Single holding register; a new byte always lands, flagging overrun if unread.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data    <= '0;
      data_ready <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (complete) begin
        rx_data    <= shift_q;
        data_ready <= 1'b1;
        if (data_ready && !rd_ack) begin
          overrun <= 1'b1;
        end
      end else if (rd_ack) begin
        data_ready <= 1'b0;
        overrun    <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx.
// The DUT runs at a reduced clock (divisor 8, 128 clk per bit) to keep runs short;
// glitch length and busy bound are scaled from the 2496-clk bit time.
module tb_uart_rx;

  localparam int unsigned BAUD       = 9600;
  localparam int unsigned OVS        = 16;
  localparam int unsigned DIVT       = 8;
  localparam int unsigned CLKF       = BAUD * OVS * DIVT;
  localparam int          BIT        = DIVT * OVS;
  localparam int          GLITCH     = (BIT * 500) / 2496;
  localparam int          BUSY_BOUND = (BIT * 1250) / 2496;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       Parity_sel = 1'b0;
  logic       rd_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, data_ready, parity_err, frame_err, overrun, busy;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       psel;
    logic       pbit;
    logic       perr;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[6];
  int   checks = 0;
  int   failures = 0;
  int   nvalid = 0;
  logic prev_valid = 1'b0;

  uart_rx #(
    .CLK_FREQ  (CLKF),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .Parity_sel(Parity_sel),
    .rd_ack    (rd_ack),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .data_ready(data_ready),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    idle_clks(BIT);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic psel, input logic pbit,
                            input logic stop);
    Parity_sel = psel;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(pbit);
    drive_bit(stop);
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic perr, input logic ferr);
    exp_t e;
    e.data = d;
    e.perr = perr;
    e.ferr = ferr;
    sb.push_back(e);
  endtask

  task automatic ack();
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
  endtask

  // Scoreboard consumer: every completed frame must match the oldest expectation.
  always @(negedge clk) begin
    if (rx_valid) begin
      nvalid++;
      check("valid_single_cycle", {31'd0, prev_valid}, 32'd0);
      check("frame_expected", {31'd0, sb.size() > 0}, 32'd1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("frame_parity_err", {31'd0, parity_err}, {31'd0, mon_e.perr});
        check("frame_frame_err", {31'd0, frame_err}, {31'd0, mon_e.ferr});
`ifndef UART_RX_FIFO_EN
        check("frame_rx_data", {24'd0, rx_data}, {24'd0, mon_e.data});
`endif
      end
    end
    prev_valid = rx_valid;
  end

  initial begin
    #(90000 * 10);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  base;
    bit  found;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{8'h5A, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'h00, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{8'h07, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'hFE, 1'b0, 1'b1, 1'b0};

    // Reset state.
    idle_clks(3);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_data_ready", {31'd0, data_ready}, 32'd0);
    check("rst_parity_err", {31'd0, parity_err}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    idle_clks(10);

    // Table-driven frames, each read back and acknowledged.
    for (int i = 0; i < 6; i++) begin
      expect_frame(vecs[i].data, vecs[i].perr, 1'b0);
      send_frame(vecs[i].data, vecs[i].psel, vecs[i].pbit, 1'b1);
      idle_clks(20);
      check("vec_data_ready", {31'd0, data_ready}, 32'd1);
      check("vec_rx_data", {24'd0, rx_data}, {24'd0, vecs[i].data});
      check("vec_parity_err", {31'd0, parity_err}, {31'd0, vecs[i].perr});
      ack();
      check("vec_ack_clears", {31'd0, data_ready}, 32'd0);
      check("vec_overrun", {31'd0, overrun}, 32'd0);
    end

    // Start-bit glitch: rejected, busy drops before the bound.
    base = nvalid;
    rx = 1'b0;
    idle_clks(10);
    check("glitch_busy_rises", {31'd0, busy}, 32'd1);
    idle_clks(GLITCH - 10);
    rx = 1'b1;
    found = 1'b0;
    for (int k = GLITCH; k < BUSY_BOUND && !found; k++) begin
      @(negedge clk);
      if (!busy) found = 1'b1;
    end
    check("glitch_busy_falls", {31'd0, found}, 32'd1);
    idle_clks(BIT);
    check("glitch_no_frame", nvalid, base);

    // Low stop bit followed by a held-low line.
    expect_frame(8'h55, 1'b0, 1'b1);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    idle_clks(3 * BIT);
    check("break_busy", {31'd0, busy}, 32'd1);
    check("break_frame_err", {31'd0, frame_err}, 32'd1);
    check("break_rx_data", {24'd0, rx_data}, 32'h55);
    ack();
    rx = 1'b1;
    idle_clks(20);
    check("break_exit_idle", {31'd0, busy}, 32'd0);
    expect_frame(8'h12, 1'b0, 1'b0);
    send_frame(8'h12, 1'b0, 1'b0, 1'b1);
    idle_clks(20);
    check("after_break_data", {24'd0, rx_data}, 32'h12);
    check("after_break_ferr", {31'd0, frame_err}, 32'd0);
    check("after_break_ready", {31'd0, data_ready}, 32'd1);

    // Reset during data bit 4 of 0x81 (0x12 left unread beforehand).
    base = nvalid;
    Parity_sel = 1'b0;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i == 0);
    rx = 1'b0;
    idle_clks(BIT / 4);
    check("midframe_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_rx_data", {24'd0, rx_data}, 32'd0);
    check("midrst_data_ready", {31'd0, data_ready}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_flags", {29'd0, parity_err, frame_err, overrun}, 32'd0);
    check("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
    rx = 1'b1;
    @(negedge clk);
    idle_clks(2);
    rst_n = 1'b1;
    idle_clks(3 * BIT);
    check("midrst_no_partial", nvalid, base);
    expect_frame(8'h81, 1'b0, 1'b0);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    idle_clks(20);
    check("post_rst_data", {24'd0, rx_data}, 32'h81);
    check("post_rst_ready", {31'd0, data_ready}, 32'd1);
    ack();

`ifndef UART_RX_FIFO_EN
    // Second byte overwrites an unread first byte.
    expect_frame(8'h11, 1'b0, 1'b0);
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    expect_frame(8'h22, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    idle_clks(20);
    check("ovr_rx_data", {24'd0, rx_data}, 32'h22);
    check("ovr_overrun", {31'd0, overrun}, 32'd1);
    check("ovr_ready", {31'd0, data_ready}, 32'd1);
    ack();
    check("ovr_ack_ready", {31'd0, data_ready}, 32'd0);
    check("ovr_ack_clears", {31'd0, overrun}, 32'd0);
`else
    // Five bytes into a four-entry FIFO: the fifth is dropped.
    for (int v = 1; v <= 5; v++) begin
      logic [7:0] b;
      b = {v[3:0], v[3:0]};
      expect_frame(b, 1'b0, 1'b0);
      send_frame(b, 1'b0, ^b, 1'b1);
    end
    idle_clks(20);
    check("fifo_overrun", {31'd0, overrun}, 32'd1);
    check("fifo_ready", {31'd0, data_ready}, 32'd1);
    for (int r = 1; r <= 4; r++) begin
      logic [7:0] b;
      b = {r[3:0], r[3:0]};
      check("fifo_read", {24'd0, rx_data}, {24'd0, b});
      ack();
    end
    check("fifo_empty", {31'd0, data_ready}, 32'd0);
`endif

    idle_clks(10);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
